// File: rtl/store_narrow_unit_pkg.sv
// rtl/store_narrow_unit_pkg.sv - shared encodings for the store narrowing path
// Access-size codes, beat FSM states and byte-enable constants.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] BE_ALL  = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/store_narrow_unit_if.sv
// rtl/store_narrow_unit_if.sv - request, memory-beat and status bundle
// The master drives requests and accepts beats; the slave is the narrowing unit.
interface store_narrow_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;

  logic              done;
  logic              err;
  logic              fits;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err, fits
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err, fits
  );
endinterface

// File: rtl/store_narrow_unit_lane_fmt.sv
// rtl/store_narrow_unit_lane_fmt.sv - combinational beat formatter
// Maps size/address/data/beat to halfword data, byte enables, lossless flag and reject.
module store_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  input  logic        beat_i,
  output logic [15:0] wdata_o,
  output logic [1:0]  be_o,
  output logic        fits_o,
  output logic        misalign_o
);

  always_comb begin
    wdata_o    = 16'h0000;
    be_o       = 2'b00;
    fits_o     = 1'b0;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        wdata_o    = {data_i[7:0], data_i[7:0]};
        be_o       = addr_lo_i[0] ? BE_HI : BE_LO;
        // Lossless when every bit above the byte sign bit matches it.
        fits_o     = (&data_i[31:7]) | ~(|data_i[31:7]);
      end
      SZ_HALF: begin
        wdata_o    = data_i[15:0];
        be_o       = BE_ALL;
        fits_o     = (&data_i[31:15]) | ~(|data_i[31:15]);
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        wdata_o    = beat_i ? data_i[31:16] : data_i[15:0];
        be_o       = BE_ALL;
        fits_o     = 1'b1;
        misalign_o = |addr_lo_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// rtl/store_narrow_unit.sv - 32-bit store to 16-bit memory port narrowing unit
// Latches a store request and issues one or two halfword beats with byte enables.
module store_narrow_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  store_narrow_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       data_q, data_d;

  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fits_q, fits_d;

  logic [1:0]        fmt_size;
  logic [1:0]        fmt_addr_lo;
  logic [31:0]       fmt_data;
  logic              fmt_beat;
  logic [15:0]       fmt_wdata;
  logic [1:0]        fmt_be;
  logic              fmt_fits;
  logic              fmt_misalign;

  logic              hs;

  assign hs = mem_valid_q & bus.mem_ready;

  // In IDLE the formatter judges the incoming request; afterwards it works
  // on the latched one, pre-computing the upper half while BEAT0 is out.
  always_comb begin
    if (state_q == IDLE) begin
      fmt_size    = bus.req_size;
      fmt_addr_lo = bus.req_addr[1:0];
      fmt_data    = bus.req_data;
    end else begin
      fmt_size    = size_q;
      fmt_addr_lo = addr_lo_q;
      fmt_data    = data_q;
    end
    fmt_beat = (state_q == BEAT0);
  end

  store_lane_fmt u_fmt (
    .size_i     (fmt_size),
    .addr_lo_i  (fmt_addr_lo),
    .data_i     (fmt_data),
    .beat_i     (fmt_beat),
    .wdata_o    (fmt_wdata),
    .be_o       (fmt_be),
    .fits_o     (fmt_fits),
    .misalign_o (fmt_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !fmt_misalign) state_d = BEAT0;
      end
      BEAT0: begin
        if (hs) state_d = (size_q == SZ_WORD) ? BEAT1 : IDLE;
      end
      BEAT1: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fits_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fmt_misalign) begin
            err_d = 1'b1;
          end else begin
            size_d      = bus.req_size;
            addr_lo_d   = bus.req_addr[1:0];
            data_d      = bus.req_data;
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:1], 1'b0};
            mem_wdata_d = fmt_wdata;
            mem_be_d    = fmt_be;
          end
        end
      end
      BEAT0: begin
        if (hs) begin
          if (size_q == SZ_WORD) begin
            // Wraps naturally at the top of the address space.
            mem_addr_d  = mem_addr_q + ADDR_W'(2);
            mem_wdata_d = fmt_wdata;
            mem_be_d    = BE_ALL;
          end else begin
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
            fits_d      = fmt_fits;
          end
        end
      end
      BEAT1: begin
        if (hs) begin
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          fits_d      = fmt_fits;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q      <= SZ_BYTE;
      addr_lo_q   <= 2'b00;
      data_q      <= 32'h0000_0000;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      mem_be_q    <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fits_q      <= 1'b0;
    end else begin
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fits_q      <= fits_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.fits      = fits_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb/tb_store_narrow_unit.sv - self-checking bench for store_narrow_unit
// Directed and randomized stores checked against an arithmetic reference model.
module tb_store_narrow_unit;

  typedef struct packed {
    logic        rej;
    logic [1:0]  n;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [1:0]  b0;
    logic [1:0]  b1;
    logic        fits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  store_narrow_unit_if #(.ADDR_W(32)) bif ();

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Expected beats from the store rules: value range for fits, modulo for alignment.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size);
    exp_t e;
    int   sv;
    e    = '0;
    sv   = $signed(data);
    e.a0 = addr & 32'hFFFF_FFFE;
    e.a1 = e.a0 + 32'd2;
    case (size)
      2'd0: begin
        e.n    = 2'd1;
        e.w0   = data[7:0] * 16'h0101;
        e.b0   = (addr % 2 != 0) ? 2'b10 : 2'b01;
        e.fits = (sv >= -128) && (sv <= 127);
      end
      2'd1: begin
        e.rej  = (addr % 2 != 0);
        e.n    = 2'd1;
        e.w0   = data[15:0];
        e.b0   = 2'b11;
        e.fits = (sv >= -32768) && (sv <= 32767);
      end
      2'd2: begin
        e.rej  = (addr % 4 != 0);
        e.n    = 2'd2;
        e.w0   = data[15:0];
        e.w1   = data[31:16];
        e.b0   = 2'b11;
        e.b1   = 2'b11;
        e.fits = 1'b1;
      end
      default: e.rej = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle and follows it to its done/err cycle.
  // s0/s1 are stall cycles for each beat; negative picks a random count.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input int s0, input int s1,
                         input string tag);
    exp_t        e;
    int          st;
    logic [31:0] ea;
    logic [15:0] ew;
    logic [1:0]  eb;
    e = model(addr, data, size);
    check({tag, ":req_ready"}, bif.req_ready, 1);
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    bif.req_data  = data;
    bif.req_size  = size;
    bif.mem_ready = 1'b0;
    step();
    bif.req_valid = 1'b0;
    bif.req_addr  = $urandom;
    bif.req_data  = $urandom;
    bif.req_size  = 2'($urandom_range(0, 3));
    if (e.rej) begin
      check({tag, ":err"}, bif.err, 1);
      check({tag, ":rej_valid"}, bif.mem_valid, 0);
      check({tag, ":rej_ready"}, bif.req_ready, 1);
      check({tag, ":rej_done"}, bif.done, 0);
    end else begin
      for (int k = 0; k < int'(e.n); k++) begin
        st = (k == 0) ? s0 : s1;
        if (st < 0) st = $urandom_range(0, 3);
        ea = (k == 0) ? e.a0 : e.a1;
        ew = (k == 0) ? e.w0 : e.w1;
        eb = (k == 0) ? e.b0 : e.b1;
        for (int s = 0; s <= st; s++) begin
          check({tag, ":mem_valid"}, bif.mem_valid, 1);
          check({tag, ":mem_addr"}, bif.mem_addr, ea);
          check({tag, ":mem_wdata"}, bif.mem_wdata, ew);
          check({tag, ":mem_be"}, bif.mem_be, eb);
          check({tag, ":busy_done"}, bif.done, 0);
          check({tag, ":busy_err"}, bif.err, 0);
          check({tag, ":busy_ready"}, bif.req_ready, 0);
          bif.mem_ready = (s == st);
          step();
        end
        bif.mem_ready = 1'b0;
      end
      check({tag, ":done"}, bif.done, 1);
      check({tag, ":fits"}, bif.fits, e.fits);
      check({tag, ":end_valid"}, bif.mem_valid, 0);
      check({tag, ":end_err"}, bif.err, 0);
    end
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, ":idle_done"}, bif.done, 0);
    check({tag, ":idle_err"}, bif.err, 0);
    check({tag, ":idle_valid"}, bif.mem_valid, 0);
    check({tag, ":idle_ready"}, bif.req_ready, 1);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          v;

    bif.req_valid = 1'b1;
    bif.req_addr  = 32'h0000_1000;
    bif.req_data  = 32'h1234_5678;
    bif.req_size  = 2'd0;
    bif.mem_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    check("rst:req_ready", bif.req_ready, 1);
    check("rst:mem_valid", bif.mem_valid, 0);
    check("rst:mem_addr", bif.mem_addr, 0);
    check("rst:mem_wdata", bif.mem_wdata, 0);
    check("rst:mem_be", bif.mem_be, 0);
    check("rst:done", bif.done, 0);
    check("rst:err", bif.err, 0);
    check("rst:fits", bif.fits, 0);
    bif.req_valid = 1'b0;
    bif.mem_ready = 1'b0;
    rst = 1'b0;
    idle_check("post_rst");

    run_req(32'h0000_1001, 32'hFFFF_FF80, 2'd0, 0, 0, "byte");
    check("byte:wdata_const", 64'(model(32'h0000_1001, 32'hFFFF_FF80, 2'd0).w0), 64'h8080);
    idle_check("byte");
    run_req(32'h0000_2002, 32'h0001_8000, 2'd1, 0, 0, "half");
    idle_check("half");
    run_req(32'h0000_3000, 32'hDEAD_BEEF, 2'd2, 2, 0, "word_stall");
    idle_check("word_stall");

    run_req(32'h0000_4002, 32'h1111_2222, 2'd2, 0, 0, "rej_word");
    run_req(32'h0000_4000, 32'h1111_2222, 2'd3, 0, 0, "rej_rsvd");
    run_req(32'h0000_4004, 32'hFFFF_C000, 2'd1, 0, 0, "after_err");
    idle_check("after_err");

    bif.req_valid = 1'b1;
    bif.req_addr  = 32'h0000_5000;
    bif.req_data  = 32'hCAFE_F00D;
    bif.req_size  = 2'd2;
    step();
    bif.req_valid = 1'b0;
    bif.mem_ready = 1'b1;
    step();
    bif.mem_ready = 1'b0;
    step();
    check("rstmid:beat1_valid", bif.mem_valid, 1);
    check("rstmid:beat1_addr", bif.mem_addr, 32'h0000_5002);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid:valid", bif.mem_valid, 0);
    check("rstmid:addr", bif.mem_addr, 0);
    check("rstmid:be", bif.mem_be, 0);
    check("rstmid:ready", bif.req_ready, 1);
    step();
    check("rstmid:done_in_rst", bif.done, 0);
    rst = 1'b0;
    step();
    check("rstmid:done_after", bif.done, 0);
    check("rstmid:err_after", bif.err, 0);
    run_req(32'h0000_6002, 32'h0000_007F, 2'd0, 1, 0, "byte_after_rst");
    idle_check("byte_after_rst");

    run_req(32'hFFFF_FFFC, 32'h8765_4321, 2'd2, 0, 1, "word_wrap");
    run_req(32'h0000_7003, 32'h0000_0080, 2'd0, 0, 0, "b2b_done");
    idle_check("b2b_done");

    for (int i = 0; i < 40; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0: data = $urandom;
        1: begin v = $urandom_range(0, 511); data = 32'(v - 256); end
        default: begin v = $urandom_range(0, 131071); data = 32'(v - 65536); end
      endcase
      run_req(addr, data, size, -1, -1, "rand");
      if ($urandom_range(0, 3) == 0) idle_check("rand");
    end
    idle_check("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path narrowing unit for the 32-bit datapath: accepts a 32-bit register value with an access size and byte address, and writes it to the 16-bit data-memory port as one or two halfword beats with byte-lane enables. It is the write-side counterpart of the load-path sign extension. It also reports whether the narrowed value is lossless, meaning sign-extending it reproduces the original register value. It sits between the execute/memory pipeline stage and the data memory.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: unit can accept a request; high exactly when state = IDLE.
- `req_addr` in ADDR_W: byte address.
- `req_data` in 32: register value to store.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `mem_valid` out 1: memory beat valid.
- `mem_ready` in 1: memory accepts the beat.
- `mem_addr` out ADDR_W: halfword-aligned beat address (bit 0 always 0).
- `mem_wdata` out 16: beat data.
- `mem_be` out 2: byte enables; bit 0 is the low byte (even address).
- `done` out 1: one-cycle pulse when the store completes.
- `err` out 1: one-cycle pulse when a request is rejected.
- `fits` out 1: lossless-narrowing flag; valid only while `done` is high.

## Operation
- Accept on `req_valid && req_ready`. Latch addr, data and size.
- Reject conditions: size 11, halfword with addr[0]=1, word with addr[1:0]≠00.
  - Rejected request: no memory beat; state stays IDLE; `err` pulses the next cycle.
- Byte store: one beat. `mem_addr = {addr[ADDR_W-1:1],0}`, `mem_wdata = {data[7:0],data[7:0]}`, `mem_be` = 01 if addr[0]=0, else 10.
- Halfword store: one beat. `mem_wdata = data[15:0]`, `mem_be = 11`.
- Word store: two beats, little-endian.
  - BEAT0: `addr`, `data[15:0]`, be 11.
  - BEAT1: `addr+2`, `data[31:16]`, be 11.
- `fits`:
  - byte: 1 iff data[31:7] is all zeros or all ones.
  - halfword: 1 iff data[31:15] is all zeros or all ones.
  - word: always 1.
- FSM:
  - IDLE → BEAT0 on a valid accept.
  - BEAT0 → IDLE on handshake for byte/halfword; → BEAT1 on handshake for word.
  - BEAT1 → IDLE on handshake.
- Beat handshake: `mem_valid` stays high and addr/wdata/be stay stable until `mem_ready` is seen high. `mem_valid` never drops without a handshake, except on reset.
- `done`/`fits` are registered and pulse in the cycle after the final handshake. The unit is back in IDLE in that same cycle, so a new request can be accepted while `done` is high.
- Address arithmetic wraps modulo 2^ADDR_W; for example, a word at 0xFFFF_FFFC gives BEAT1 at 0xFFFF_FFFE.

## Timing
- Request accepted at edge N → `mem_valid` high in cycle N+1.
- With `mem_ready` held high:
  - byte/halfword: `done` in cycle N+2.
  - word: BEAT1 in cycle N+2, `done` in cycle N+3.
- Each cycle `mem_ready` is low stretches the current beat by one cycle.
- Reject: accepted at N → `err` in cycle N+1, with `req_ready` still high.
- Reset values (while `rst` is high): state IDLE, `req_ready` 1 (no accept while in reset), `mem_valid` 0, `mem_addr` 0, `mem_wdata` 0, `mem_be` 00, `done` 0, `err` 0, `fits` 0.
- Reset mid-operation: asynchronously clears state and outputs. An in-flight beat is abandoned; no `done` or `err` follows.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state type (IDLE, BEAT0, BEAT1);
  - halfword-enable constant `BE_ALL = 2'b11`.
- One natural sub-module: `store_lane_fmt`. Purely combinational; takes {size, addr[1:0], data, beat index} and returns wdata, be, fits and misalign.
- Top level holds the FSM, latches and the output registers.

## Test plan
- Byte store: addr 0x1001, data 0xFFFF_FF80, `mem_ready`=1 → one beat: addr 0x1000, wdata 0x8080, be 10; `done` at N+2 with `fits`=1.
- Halfword store: addr 0x2002, data 0x0001_8000 → wdata 0x8000, be 11; `fits`=0.
- Word store: addr 0x3000, data 0xDEAD_BEEF, `mem_ready` low for 2 cycles on BEAT0 → beats (0x3000, 0xBEEF) then (0x3002, 0xDEAD); BEAT0 payload stable while stalled; `done` at N+5.
- Misaligned word at 0x4002, then size 11 → `err` pulses for each, no `mem_valid`; a back-to-back valid halfword request is accepted in the `err` cycle.
- Reset asserted during the BEAT1 stall → `mem_valid` drops immediately, no `done`; after reset a new byte store completes normally.
- Word at 0xFFFF_FFFC → BEAT1 addr 0xFFFF_FFFE; `done` followed by an immediate new request accepted in the `done` cycle.
